// File: rtl/riscx_pkg.sv
// riscx_pkg: shared data-memory map constants and the arbiter FSM state type
package riscx_pkg;
  localparam logic [31:0] DMEM_BASE  = 32'h1001_0000;
  localparam int          DMEM_DEPTH = 256;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; ports clock/reset_n, req_a/req_b requests, advance strobe, one-hot grant (bit0=A, bit1=B)
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_b_q, last_b_d;
  always_comb begin
    grant    = req_a && req_b ? (last_b_q ? 2'b01 : 2'b10) : {req_b, req_a};
    last_b_d = advance && |grant ? grant[1] : last_b_q;
  end
  // Pointer resets to B so that A wins the first tie.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) last_b_q <= 1'b1;
    else          last_b_q <= last_b_d;
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin arbitration of requesters A/B onto one data memory; ports: clock, reset_n, A/B request/response channels, m* memory strobes/address/data, mQ read data
module data_memory_arbiter
  import riscx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
  parameter int          DEPTH_WORDS = DMEM_DEPTH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        aValid,
  input  logic        aWrite,
  input  logic [31:0] aAddress,
  input  logic [31:0] aData,
  output logic        aReady,
  output logic        aRespValid,
  output logic        aError,
  output logic [31:0] aQ,
  input  logic        bValid,
  input  logic        bWrite,
  input  logic [31:0] bAddress,
  input  logic [31:0] bData,
  output logic        bReady,
  output logic        bRespValid,
  output logic        bError,
  output logic [31:0] bQ,
  output logic        mWrite,
  output logic        mRead,
  output logic [31:0] mAddress,
  output logic [31:0] mData,
  input  logic [31:0] mQ
);
  // One past the last valid byte, kept at 33 bits so the range never wraps.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  dmem_state_e state_q, state_d;
  logic        wr_q, err_q, port_q;
  logic [31:0] addr_q, data_q, resp_q;
  logic        idle, accept, sel_wr, sel_err, access, resp;
  logic [31:0] sel_addr, sel_data;
  logic [1:0]  grant;
  // Gating with reset_n keeps ready low while reset is held.
  assign idle = state_q == IDLE && reset_n;
  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset_n(reset_n),
    .req_a  (aValid & idle),
    .req_b  (bValid & idle),
    .advance(idle),
    .grant  (grant)
  );
  always_comb begin
    accept   = |grant;
    sel_wr   = grant[1] ? bWrite : aWrite;
    sel_addr = grant[1] ? bAddress : aAddress;
    sel_data = grant[1] ? bData : aData;
    sel_err  = sel_addr[1:0] != 2'b00 || sel_addr < BASE_ADDR || {1'b0, sel_addr} >= END_ADDR;
    state_d  = state_q == IDLE ? (accept ? ACCESS : IDLE) : state_q == ACCESS ? RESP : IDLE;
    access   = state_q == ACCESS;
    resp     = state_q == RESP;
    aReady   = grant[0];
    bReady   = grant[1];
    mWrite   = access && wr_q && !err_q;
    mRead    = access && !wr_q && !err_q;
    mAddress = access ? addr_q : 32'h0;
    mData    = access ? data_q : 32'h0;
    aRespValid = resp && !port_q;
    bRespValid = resp && port_q;
    aError   = aRespValid && err_q;
    bError   = bRespValid && err_q;
    aQ       = aRespValid ? resp_q : 32'h0;
    bQ       = bRespValid ? resp_q : 32'h0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      resp_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q   <= sel_wr;
        err_q  <= sel_err;
        port_q <= grant[1];
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
      if (access) resp_q <= mRead ? mQ : 32'h0;
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed self-checking bench for data_memory_arbiter with a behavioural data memory
module tb_data_memory_arbiter;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        aValid = 0, aWrite = 0, bValid = 0, bWrite = 0;
  logic [31:0] aAddress = 0, aData = 0, bAddress = 0, bData = 0, mQ = 0;
  logic        aReady, aRespValid, aError, bReady, bRespValid, bError, mWrite, mRead;
  logic [31:0] aQ, bQ, mAddress, mData;
  logic [31:0] mem [256];
  int          checks = 0, failures = 0;

  data_memory_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .aValid(aValid), .aWrite(aWrite), .aAddress(aAddress), .aData(aData),
    .aReady(aReady), .aRespValid(aRespValid), .aError(aError), .aQ(aQ),
    .bValid(bValid), .bWrite(bWrite), .bAddress(bAddress), .bData(bData),
    .bReady(bReady), .bRespValid(bRespValid), .bError(bError), .bQ(bQ),
    .mWrite(mWrite), .mRead(mRead), .mAddress(mAddress), .mData(mData), .mQ(mQ)
  );

  always #5 clock = ~clock;
  always @(negedge clock) if (mRead) mQ <= mem[mAddress[9:2]];
  always @(posedge clock) if (mWrite) mem[mAddress[9:2]] <= mData;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xact(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] dat,
                      output logic [31:0] q, output bit err, output int lat, output bit mem_seen);
    bit acc = 0;
    int t0 = 0;
    q = 0; err = 0; lat = -1; mem_seen = 0;
    if (port) begin bValid = 1; bWrite = wr; bAddress = addr; bData = dat; end
    else      begin aValid = 1; aWrite = wr; aAddress = addr; aData = dat; end
    for (int t = 0; t < 20 && lat < 0; t++) begin
      @(negedge clock);
      if (mRead || mWrite) mem_seen = 1;
      if (!acc && (port ? bReady : aReady)) begin acc = 1; t0 = t; end
      if (acc && (port ? bRespValid : aRespValid)) begin
        lat = t - t0;
        q   = port ? bQ : aQ;
        err = port ? bError : aError;
      end
      @(posedge clock); #1;
      if (acc) begin aValid = 0; bValid = 0; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] q;
    logic [7:0]  gseq;
    bit          err, seen, rv, both;
    int          lat;
    foreach (mem[i]) mem[i] = 32'h0;
    aValid = 1; aAddress = 32'h1001_0000; bValid = 1; bAddress = 32'h1001_0004;
    #2;
    check("rst_aReady", aReady, 0);
    check("rst_bReady", bReady, 0);
    check("rst_mRead", mRead, 0);
    check("rst_mAddress", mAddress, 0);
    check("rst_aRespValid", aRespValid, 0);
    // Both valid from the first cycle after reset: A first, then alternation.
    @(posedge clock); #1 reset_n = 1;
    gseq = 0; both = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (aReady || bReady) gseq = {gseq[5:0], bReady, aReady};
      if ((aReady && bReady) || (mRead && mWrite)) both = 1;
    end
    @(posedge clock); #1 aValid = 0; bValid = 0;
    check("rr_sequence", gseq, 8'h66);
    check("rr_exclusive", both, 0);
    // Write then read back.
    xact(0, 1, 32'h1001_0004, 32'hDEAD_BEEF, q, err, lat, seen);
    check("wr_latency", lat, 2);
    check("wr_mem_pulse", seen, 1);
    xact(0, 0, 32'h1001_0004, 32'h0, q, err, lat, seen);
    check("rd_latency", lat, 2);
    check("rd_data", q, 32'hDEAD_BEEF);
    check("rd_error", err, 0);
    // Misaligned and out-of-range requests from B.
    xact(1, 0, 32'h1001_0002, 32'h0, q, err, lat, seen);
    check("misal_error", err, 1);
    check("misal_q", q, 0);
    check("misal_no_mem", seen, 0);
    xact(1, 0, 32'h1001_0400, 32'h0, q, err, lat, seen);
    check("oor_error", err, 1);
    check("oor_q", q, 0);
    check("oor_no_mem", seen, 0);
    check("oor_latency", lat, 2);
    // Last word is in range; the word below the base is not.
    xact(1, 1, 32'h1001_03FC, 32'h0BAD_CAFE, q, err, lat, seen);
    check("last_wr_error", err, 0);
    xact(0, 0, 32'h1001_03FC, 32'h0, q, err, lat, seen);
    check("last_rd_error", err, 0);
    check("last_rd_data", q, 32'h0BAD_CAFE);
    xact(0, 0, 32'h1000_FFFC, 32'h0, q, err, lat, seen);
    check("below_error", err, 1);
    check("below_no_mem", seen, 0);
    // A payload changes while B is being served; the accept-cycle value wins.
    bValid = 1; bWrite = 0; bAddress = 32'h1001_0000;
    @(negedge clock); check("hold_b_ready", bReady, 1);
    @(posedge clock); #1 bValid = 0; aValid = 1; aWrite = 1; aAddress = 32'h1001_0010; aData = 32'h1111_1111;
    @(negedge clock); check("hold_busy_access", aReady, 0);
    @(posedge clock); #1 aAddress = 32'h1001_0014; aData = 32'h2222_2222;
    @(negedge clock); check("hold_busy_resp", aReady, 0);
    check("hold_b_resp", bRespValid, 1);
    @(posedge clock); #1;
    @(negedge clock); check("hold_a_ready", aReady, 1);
    @(posedge clock); #1 aValid = 0; aAddress = 32'h1001_0018; aData = 32'h3333_3333;
    @(negedge clock);
    check("hold_mWrite", mWrite, 1);
    check("hold_mAddress", mAddress, 32'h1001_0014);
    check("hold_mData", mData, 32'h2222_2222);
    @(posedge clock); #1;
    @(negedge clock); check("hold_a_resp", aRespValid, 1);
    @(posedge clock); #1;
    xact(0, 0, 32'h1001_0010, 32'h0, q, err, lat, seen);
    check("hold_first_unwritten", q, 0);
    // Reset during the ACCESS cycle of a write.
    aValid = 1; aWrite = 1; aAddress = 32'h1001_0008; aData = 32'hCAFE_F00D;
    @(negedge clock); check("rstmid_ready", aReady, 1);
    @(posedge clock); #1 aValid = 0;
    check("rstmid_mWrite_before", mWrite, 1);
    reset_n = 0; #1;
    check("rstmid_mWrite_drop", mWrite, 0);
    check("rstmid_mAddress", mAddress, 0);
    rv = 0;
    repeat (2) begin @(negedge clock); if (aRespValid || bRespValid) rv = 1; end
    @(posedge clock); #1 reset_n = 1;
    check("rstmid_no_resp", rv, 0);
    xact(0, 0, 32'h1001_0008, 32'h0, q, err, lat, seen);
    check("rstmid_idle_latency", lat, 2);
    check("rstmid_word_unchanged", q, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
